// File: rtl/mac_rx_frame_dispatch.sv
// Read-side dispatcher for a MAC receive port: pops TTE/BE descriptors (TTE first),
// forwards good frames through a 2-entry skid buffer and drains errored frames.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | wait for a descriptor; pick TTE over BE
// PTR_RD  | pop the selected descriptor FIFO for one cycle
// PTR_CAP | latch N/err; zero-length counts as a drop
// FWD     | stream N bytes to the switch core under valid/ready
// DROP    | pop and discard N bytes, then count the drop
module mac_rx_frame_dispatch #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ptr_fifo_empty,
    output logic                  ptr_fifo_rd,
    input  logic [15:0]           ptr_fifo_dout,
    output logic                  data_fifo_rd,
    input  logic [7:0]            data_fifo_dout,
    input  logic                  tteptr_fifo_empty,
    output logic                  tteptr_fifo_rd,
    input  logic [15:0]           tteptr_fifo_dout,
    output logic                  tte_fifo_rd,
    input  logic [7:0]            tte_fifo_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  out_tte,
    output logic [12:0]           out_len,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [15:0]           fwd_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_RD,
        S_PTR_CAP,
        S_FWD,
        S_DROP
    } state_t;

    localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  tte_q, tte_d;
    logic [12:0]           len_q, len_d;
    logic [12:0]           rd_left_q, rd_left_d;
    logic [12:0]           tx_left_q, tx_left_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [7:0]            buf0_q, buf0_d;
    logic [7:0]            buf1_q, buf1_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [15:0]           fwd_cnt_q, fwd_cnt_d;

    logic [12:0] desc_len;
    logic        desc_err;
    logic [7:0]  din;
    logic        head_valid;
    logic        pop;
    logic        push;
    logic        rd_issue;
    logic        drop_rd;

    // Bit 13 of the descriptor carries no meaning for this block.
    logic unused_desc_bit;
    assign unused_desc_bit = ^{ptr_fifo_dout[13], tteptr_fifo_dout[13]};

    always_comb begin
        desc_len   = tte_q ? tteptr_fifo_dout[12:0] : ptr_fifo_dout[12:0];
        desc_err   = tte_q ? (|tteptr_fifo_dout[15:14]) : (|ptr_fifo_dout[15:14]);
        din        = tte_q ? tte_fifo_dout : data_fifo_dout;
        // The byte still sitting on the FIFO output acts as the head when the buffer is empty.
        head_valid = (state_q == S_FWD) && ((occ_q != 2'd0) || inflight_q);
        pop        = head_valid && out_ready;
        push       = inflight_q && !(pop && (occ_q == 2'd0));
        rd_issue   = (state_q == S_FWD) && (rd_left_q != 13'd0)
                     && ((occ_q + {1'b0, inflight_q}) < 2'd2);
        drop_rd    = (state_q == S_DROP);

        state_d    = state_q;
        tte_d      = tte_q;
        len_d      = len_q;
        rd_left_d  = rd_left_q;
        tx_left_d  = tx_left_q;
        occ_d      = occ_q;
        inflight_d = rd_issue;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        drop_cnt_d = drop_cnt_q;
        fwd_cnt_d  = fwd_cnt_q;

        if (pop && (occ_q != 2'd0)) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0) begin
                buf0_d = din;
            end else begin
                buf1_d = din;
            end
            occ_d = occ_d + 2'd1;
        end
        if (rd_issue || drop_rd) begin
            rd_left_d = rd_left_q - 13'd1;
        end
        if (pop) begin
            tx_left_d = tx_left_q - 13'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!tteptr_fifo_empty) begin
                    tte_d   = 1'b1;
                    state_d = S_PTR_RD;
                end else if (!ptr_fifo_empty) begin
                    tte_d   = 1'b0;
                    state_d = S_PTR_RD;
                end
            end
            S_PTR_RD: begin
                state_d = S_PTR_CAP;
            end
            S_PTR_CAP: begin
                len_d     = desc_len;
                rd_left_d = desc_len;
                tx_left_d = desc_len;
                if (desc_len == 13'd0) begin
                    if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + DROP_ONE;
                    end
                    state_d = S_IDLE;
                end else if (desc_err) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_FWD;
                end
            end
            S_DROP: begin
                if (rd_left_q == 13'd1) begin
                    if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + DROP_ONE;
                    end
                    state_d = S_IDLE;
                end
            end
            S_FWD: begin
                if (pop && (tx_left_q == 13'd1)) begin
                    fwd_cnt_d = fwd_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            tte_q      <= 1'b0;
            len_q      <= 13'd0;
            rd_left_q  <= 13'd0;
            tx_left_q  <= 13'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= 8'd0;
            buf1_q     <= 8'd0;
            drop_cnt_q <= '0;
            fwd_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            tte_q      <= tte_d;
            len_q      <= len_d;
            rd_left_q  <= rd_left_d;
            tx_left_q  <= tx_left_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            drop_cnt_q <= drop_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
        end
    end

    assign ptr_fifo_rd    = (state_q == S_PTR_RD) && !tte_q;
    assign tteptr_fifo_rd = (state_q == S_PTR_RD) && tte_q;
    assign data_fifo_rd   = (rd_issue || drop_rd) && !tte_q;
    assign tte_fifo_rd    = (rd_issue || drop_rd) && tte_q;

    assign out_valid = head_valid;
    assign out_data  = !head_valid ? 8'd0 : ((occ_q != 2'd0) ? buf0_q : din);
    assign out_sof   = head_valid && (tx_left_q == len_q);
    assign out_eof   = head_valid && (tx_left_q == 13'd1);
    assign out_tte   = tte_q;
    assign out_len   = len_q;
    assign drop_cnt  = drop_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: doc/mac_rx_frame_dispatch.md
# mac_rx_frame_dispatch

Read-side consumer of a MAC receive port's FIFOs, in the `clk` domain. It pops frame descriptors from the BE and TTE pointer FIFOs with TTE taking strict priority. It then streams each good frame's bytes from the matching data FIFO to the switch core over a valid/ready byte interface. Frames flagged with a CRC or length error are drained from the data FIFO and counted, never forwarded.

## Interface
Parameters:
- `DROP_CNT_W`, 16: width of the saturating drop counter.

Ports (reset is synchronous, active-low, sampled on `clk`):
- `clk`  in  1  core clock, read side of all four MAC FIFOs.
- `rstn`  in  1  synchronous active-low reset.
- `ptr_fifo_empty`  in  1  BE descriptor FIFO empty.
- `ptr_fifo_rd`  out  1  BE descriptor pop.
- `ptr_fifo_dout`  in  16  BE descriptor: [12:0] byte count N, [14] length error, [15] CRC error, [13] ignored.
- `data_fifo_rd`  out  1  BE data pop.
- `data_fifo_dout`  in  8  BE data byte.
- `tteptr_fifo_empty`  in  1  TTE descriptor FIFO empty.
- `tteptr_fifo_rd`  out  1  TTE descriptor pop.
- `tteptr_fifo_dout`  in  16  TTE descriptor, same format as BE.
- `tte_fifo_rd`  out  1  TTE data pop.
- `tte_fifo_dout`  in  8  TTE data byte.
- `out_valid`  out  1  byte valid.
- `out_ready`  in  1  sink accepts the byte.
- `out_data`  out  8  frame byte.
- `out_sof`  out  1  first byte of frame.
- `out_eof`  out  1  last byte of frame.
- `out_tte`  out  1  frame came from the TTE path; constant for the whole frame.
- `out_len`  out  13  N of the current frame; constant for the whole frame.
- `drop_cnt`  out  DROP_CNT_W  count of dropped frames, saturating.
- `fwd_cnt`  out  16  count of forwarded frames, wrapping.

## Operation
FIFO read behaviour:
- All FIFOs are standard-mode: `dout` is valid the cycle after `rd` is asserted.
- `rd` is never asserted while the FIFO is empty.

State machine: IDLE, PTR_RD, PTR_CAP, FWD, DROP.
- **IDLE**
  - If `!tteptr_fifo_empty`, select TTE. Otherwise, if `!ptr_fifo_empty`, select BE.
  - If a path is selected, go to PTR_RD. Otherwise stay.
  - Priority is evaluated only in IDLE; a frame in progress is never pre-empted.
- **PTR_RD**
  - Assert the selected `*ptr_fifo_rd` for exactly one cycle.
- **PTR_CAP**
  - Capture the descriptor: N, err = [15]|[14], and the path.
  - If N==0: count as a drop and return to IDLE. No data reads.
  - Else if err: go to DROP.
  - Else: go to FWD.
- **DROP**
  - Assert the selected data `rd` for exactly N consecutive cycles. Discard the bytes.
  - Increment `drop_cnt` (saturating at all-ones), then go to IDLE.
- **FWD**
  - Byte path is a 2-entry skid buffer. The head entry drives `out_*`.
  - Issue a data `rd` only when: remaining reads > 0, and (buffer occupancy + reads in flight) < 2.
  - A byte is transferred when `out_valid & out_ready`.
  - `out_sof` is 1 on byte 1 only. `out_eof` is 1 on byte N only.
  - When N=1, `out_sof` and `out_eof` are both 1 on the same byte.
  - After the eof byte transfers, increment `fwd_cnt` and go to IDLE.
- Byte counters are 13 bits; N of up to 8191 is handled without wrap.
- The selected path is locked for the whole frame. The non-selected FIFOs are never read.

## Timing
- Reset values: all `*_rd` = 0, `out_valid` = 0, `out_data` = 0, `out_sof` = `out_eof` = `out_tte` = 0, `out_len` = 0, `drop_cnt` = 0, `fwd_cnt` = 0, state = IDLE, skid buffer empty.
- Latency: descriptor available in IDLE at cycle t →
  - `*ptr_fifo_rd` at t+1;
  - descriptor captured at t+2;
  - first data `rd` at t+3;
  - `out_valid` with `out_sof` at t+4.
- With `out_ready` held at 1: one byte per cycle, no bubbles inside a frame.
- The last byte of frame k is followed by `out_valid` low for at least 4 cycles before the sof of frame k+1.
- Drop throughput: 1 byte/cycle. A dropped frame of N bytes occupies N+3 cycles from IDLE back to IDLE.
- Handshake rules:
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_sof`, `out_eof`, `out_tte` and `out_len` hold stable.
  - `out_valid` never drops until the byte transfers.
- `out_ready` deasserted for any duration mid-frame: no byte is lost or duplicated; at most 2 bytes are buffered.
- Reset asserted mid-frame: all state and outputs return to reset values on the next `clk` edge. Partially read FIFO contents are not recovered; the FIFOs are reset by the same system reset.
- Both descriptor FIFOs non-empty in the same IDLE cycle: TTE is served first. BE is served afterwards only if the TTE FIFO is empty at the next IDLE.

## Test plan
- **Single good BE frame.** BE descriptor 16'h0040 with 64 data bytes 0x00..0x3F, `out_ready`=1.
  - 64 beats 0x00..0x3F, `out_sof` on 0x00, `out_eof` on 0x3F.
  - `out_tte`=0, `out_len`=64, `fwd_cnt`=1.
  - First `out_valid` 4 cycles after the ptr FIFO goes non-empty.
- **Priority.** BE and TTE descriptors (N=64 each) present in the same cycle.
  - The TTE frame is forwarded first with `out_tte`=1, then the BE frame.
  - No BE `rd` is asserted during the TTE frame.
- **CRC drop.** BE descriptor 16'h8050 with 80 bytes, followed by a good 64-byte frame.
  - Exactly 80 `data_fifo_rd` pulses with no `out_valid`; `drop_cnt`=1.
  - The second frame is forwarded intact.
- **Backpressure.** N=100; `out_ready` random at 50%, plus one 20-cycle low stretch.
  - Output sequence equals input, with no duplicates or gaps.
  - Outputs stable while stalled; at most 2 reads outstanding beyond transferred bytes.
- **Edge lengths.**
  - N=1 frame: single beat with `out_sof`=`out_eof`=1.
  - N=0 descriptor: no data reads, `drop_cnt` increments.
  - Descriptor 16'h4000|N (length error): dropped.
- **Reset mid-frame.** `rstn`=0 for 1 cycle after 30 of 64 bytes.
  - Next cycle: `out_valid`=0, counters 0, state IDLE, all `rd`=0.
